// File: rtl/fifo_bank_drain.sv
// fifo_bank_drain: read-side drain of a FIFO bank into one tagged valid/ready stream
// Ports: rd_clk/rd_rstn (clock, async active-low reset); empty/rd_data from the FIFO bank;
// rd_en one-hot pop strobe to the bank; out_valid/out_ready/out_data/out_idx/out_last output stream.
// FIFO_DRAIN_STRICT_ORDER_EN: grant only FIFO ptr (strict 0..NUM_FIFO-1 order) instead of skipping round-robin.
module fifo_bank_drain #(
  parameter int NUM_FIFO = 16,
  parameter int DATA_WIDTH = 16,
  localparam int IDX_W = $clog2(NUM_FIFO)
) (
  input  logic                           rd_clk,
  input  logic                           rd_rstn,
  input  logic [NUM_FIFO-1:0]            empty,
  input  logic [NUM_FIFO*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_FIFO-1:0]            rd_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]               out_idx,
  output logic                           out_last
);
  logic [IDX_W-1:0] ptr, gnt, gnt_q;
  logic pick_vld, issue, inflight, pop, head, tail;
  logic [1:0] count;
  logic [NUM_FIFO-1:0] elig;
  logic [DATA_WIDTH-1:0] bdata [2];
  logic [IDX_W-1:0] bidx [2];
  // the FIFO popped last cycle may still show a stale non-empty flag, so it is masked
  assign elig = ~empty & (inflight ? ~(NUM_FIFO'(1) << gnt_q) : '1);
  assign pop = out_valid && out_ready;
`ifdef FIFO_DRAIN_STRICT_ORDER_EN
  assign gnt = ptr;
  assign pick_vld = elig[ptr];
`else
  // descending scan so the lowest offset from ptr wins; pow2 size makes the add wrap
  always_comb begin
    gnt = ptr;
    pick_vld = 1'b0;
    for (int k = NUM_FIFO - 1; k >= 0; k--)
      if (elig[ptr + IDX_W'(k)]) begin
        gnt = ptr + IDX_W'(k);
        pick_vld = 1'b1;
      end
  end
`endif
  // reserve a buffer slot for every word in flight so nothing is ever dropped
  assign issue = rd_rstn && pick_vld && (3'(count) + 3'(inflight) < 3'd2 + 3'(pop));
  assign rd_en = issue ? NUM_FIFO'(1) << gnt : '0;
  always_ff @(posedge rd_clk or negedge rd_rstn)
    if (!rd_rstn) begin
      ptr <= '0;
      gnt_q <= '0;
      inflight <= 1'b0;
      count <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
      bdata <= '{default: '0};
      bidx <= '{default: '0};
    end else begin
      inflight <= issue;
      if (issue) begin
        gnt_q <= gnt;
        ptr <= gnt + IDX_W'(1);
      end
      if (inflight) begin
        bdata[tail] <= rd_data[int'(gnt_q) * DATA_WIDTH +: DATA_WIDTH];
        bidx[tail] <= gnt_q;
        tail <= ~tail;
      end
      if (pop) head <= ~head;
      count <= count + 2'(inflight) - 2'(pop);
    end
  assign out_valid = count != 2'd0;
  assign out_data = bdata[head];
  assign out_idx = bidx[head];
  assign out_last = bidx[head] == IDX_W'(NUM_FIFO - 1);
endmodule

// File: tb/tb_fifo_bank_drain.sv
// tb_fifo_bank_drain: randomized bench against a queue-based transaction model of the drain engine
module tb_fifo_bank_drain;
  localparam int N = 16, W = 16;
  logic rd_clk = 1'b0, rd_rstn = 1'b0, out_ready = 1'b0;
  logic [N-1:0] empty = '1;
  logic [N-1:0] rd_en, en_s;
  logic [N*W-1:0] rd_data = '0;
  logic out_valid, out_last;
  logic [W-1:0] out_data;
  logic [3:0] out_idx;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [W-1:0] q [N][$];
  int pd[$], pi[$], pt[$];
  int m_ptr = 0, m_last = -1;
  always #5 rd_clk = ~rd_clk;
  fifo_bank_drain #(.NUM_FIFO(N), .DATA_WIDTH(W)) dut (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .empty(empty), .rd_data(rd_data), .rd_en(rd_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
  endtask
  task automatic refresh_empty();
    for (int i = 0; i < N; i++) empty[i] = q[i].size() == 0;
  endtask
  task automatic load_all();
    for (int i = 0; i < N; i++) q[i].push_back(16'h1000 + 16'(i));
    refresh_empty();
  endtask
  task automatic model_reset();
    pd.delete();
    pi.delete();
    pt.delete();
    m_ptr = 0;
    m_last = -1;
  endtask
  task automatic chk_reset();
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
  endtask
  function automatic int pick();
`ifdef FIFO_DRAIN_STRICT_ORDER_EN
    return (q[m_ptr].size() > 0 && m_ptr != m_last) ? m_ptr : -1;
`else
    for (int k = 0; k < N; k++)
      if (q[(m_ptr + k) % N].size() > 0 && (m_ptr + k) % N != m_last) return (m_ptr + k) % N;
    return -1;
`endif
  endfunction
  task automatic step(input logic rdy);
    int g;
    logic vld, pop;
    logic [W-1:0] wd;
    out_ready = rdy;
    @(negedge rd_clk);
    vld = pt.size() > 0 && pt[0] <= cyc;
    pop = vld && rdy;
    g = (pt.size() - int'(pop) < 2) ? pick() : -1;
    chk("rd_en", 32'(rd_en), g >= 0 ? 32'd1 << g : 32'd0);
    chk("out_valid", 32'(out_valid), 32'(vld));
    if (vld) begin
      chk("out_data", 32'(out_data), 32'(pd[0]));
      chk("out_idx", 32'(out_idx), 32'(pi[0]));
      chk("out_last", 32'(out_last), 32'(pi[0] == N - 1));
    end
    en_s = rd_en;
    wd = g >= 0 ? q[g][0] : '0;
    @(posedge rd_clk);
    #1;
    cyc++;
    if (pop) begin
      void'(pd.pop_front());
      void'(pi.pop_front());
      void'(pt.pop_front());
    end
    if (g >= 0) begin
      pd.push_back(int'(wd));
      pi.push_back(g);
      pt.push_back(cyc + 1);
      m_ptr = (g + 1) % N;
    end
    m_last = g;
    for (int i = 0; i < N; i++)
      if (en_s[i] && q[i].size() > 0) rd_data[i*W +: W] = q[i].pop_front();
    refresh_empty();
  endtask
  initial begin
    q[5].push_back(16'h55AA);
    refresh_empty();
    #2 chk_reset();
    repeat (3) @(posedge rd_clk);
    #1 chk_reset();
    q[5].delete();
    refresh_empty();
    rd_rstn = 1'b1;
    repeat (20) step(1'b1);
    for (int k = 0; k < 4; k++) q[3].push_back(16'h0A00 + 16'(k));
    refresh_empty();
    repeat (12) step(1'b1);
    load_all();
    repeat (24) step(1'b1);
    load_all();
    repeat (2) step(1'b1);
    repeat (10) step(1'b0);
    repeat (30) step(1'b1);
    for (int c = 0; c < 1500; c++) begin
      repeat ($urandom_range(0, 2)) q[$urandom_range(0, N - 1)].push_back(16'($urandom));
      refresh_empty();
      step($urandom_range(0, 3) != 0);
    end
    load_all();
    repeat (4) step(1'b1);
    rd_rstn = 1'b0;
    #1 chk_reset();
    model_reset();
    @(posedge rd_clk);
    #1 chk_reset();
    rd_rstn = 1'b1;
    repeat (40) step(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
